// File: rtl/hdlc_chk_pkg.sv
// Shared types and constants for the HDLC line checker.
package hdlc_chk_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    OPEN = 2'd1,
    DATA = 2'd2
  } chanState_t;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [3:0] ABORT_RUN = 4'd7;
  localparam logic [3:0] STUFF_RUN = 4'd5;
  localparam logic [3:0] RUN_SAT   = 4'd8;
  localparam logic [3:0] WIN_FULL  = 4'd8;

  // Registered per-channel event pulses.
  typedef struct packed {
    logic flag;
    logic abort;
    logic frameEnd;
    logic alignErr;
    logic overflow;
  } chanEvt_t;

  // Ones-run update: clears on a 0, saturates at RUN_SAT.
  function automatic logic [3:0] runStep(input logic [3:0] run, input logic b);
    if (!b) return 4'd0;
    return (run == RUN_SAT) ? RUN_SAT : run + 4'd1;
  endfunction

endpackage

// File: rtl/hdlc_chk_chan.sv
// One HDLC line: raw-bit window, zero removal, HUNT/OPEN/DATA FSM, frame bit counter.
module hdlc_chk_chan
  import hdlc_chk_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  localparam int BYTE_W = $clog2(MAX_BYTES + 2)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Line,
  input  logic              Enable,
  output chanEvt_t          Evt,
  output logic              Idle,
  output logic [BYTE_W-1:0] FrameBytes
);

  // The counter includes the 7 leading bits of the closing flag, which are
  // only recognised as flag bits once its last bit arrives; leave room so
  // that the byte count can still reach MAX_BYTES+1 before saturating.
  localparam int CNT_MAX = (MAX_BYTES + 2) * 8 + 7;
  localparam int CNT_BW  = $clog2(CNT_MAX + 1);
  localparam int RAW_W   = CNT_BW - 3;

  chanState_t        state, stateNext;
  logic [7:0]        win, winNext;
  logic [3:0]        run, runNext, fill, fillNext;
  logic [CNT_BW-1:0] cnt, cntNext, cntInc, frameBits;
  logic [RAW_W-1:0]  bytesRaw;
  logic              flagHit, abortHit, stuffDrop, frameEndHit, ovf;

  assign winNext   = {win[6:0], Line};
  assign runNext   = runStep(run, Line);
  assign fillNext  = (fill == WIN_FULL) ? fill : fill + 4'd1;
  // Window must hold 8 real bits (7 stored + current) before a flag counts.
  assign flagHit   = (fill >= 4'd7) && (winNext == FLAG_PAT);
  assign abortHit  = (state != HUNT) && (runNext == ABORT_RUN);
  assign stuffDrop = !Line && (run == STUFF_RUN);
  assign cntInc    = (cnt == CNT_BW'(CNT_MAX)) ? cnt : cnt + CNT_BW'(1);
  assign frameBits = cnt - CNT_BW'(7);
  assign bytesRaw  = frameBits[CNT_BW-1:3];
  assign ovf       = int'(bytesRaw) > MAX_BYTES;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst) state <= HUNT;
    else      state <= stateNext;
  end

  // Next state, frame bit counter and frame-end decision.
  // DATA is entered once 8 kept bits follow the flag: by then at least one
  // of them must be data, so a later flag ends a non-empty frame.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    frameEndHit = 1'b0;
    unique case (state)
      HUNT: begin
        if (flagHit) begin
          stateNext = OPEN;
          cntNext   = '0;
        end
      end
      OPEN, DATA: begin
        if (abortHit) begin
          stateNext = HUNT;
          cntNext   = '0;
        end else if (flagHit) begin
          frameEndHit = (state == DATA);
          stateNext   = OPEN;
          cntNext     = '0;
        end else if (!stuffDrop) begin
          cntNext = cntInc;
          if (state == OPEN && cntInc >= CNT_BW'(8)) stateNext = DATA;
        end
      end
      default: stateNext = HUNT;
    endcase
    if (!Enable) begin
      stateNext   = HUNT;
      cntNext     = '0;
      frameEndHit = 1'b0;
    end
  end

  // Window, run, fill, counter and registered outputs; FrameBytes survives Enable low.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      win        <= '0;
      run        <= '0;
      fill       <= '0;
      cnt        <= '0;
      Evt        <= '0;
      Idle       <= 1'b0;
      FrameBytes <= '0;
    end else if (!Enable) begin
      win  <= '0;
      run  <= '0;
      fill <= '0;
      cnt  <= '0;
      Evt  <= '0;
      Idle <= 1'b0;
    end else begin
      win          <= winNext;
      run          <= runNext;
      fill         <= fillNext;
      cnt          <= cntNext;
      Evt.flag     <= flagHit;
      Evt.abort    <= abortHit;
      Evt.frameEnd <= frameEndHit;
      Evt.alignErr <= frameEndHit && (frameBits[2:0] != 3'd0);
      Evt.overflow <= frameEndHit && ovf;
      Idle         <= (stateNext == HUNT) && (runNext == RUN_SAT);
      if (frameEndHit)
        FrameBytes <= ovf ? BYTE_W'(MAX_BYTES + 1) : BYTE_W'(bytesRaw);
    end
  end

endmodule

// File: rtl/hdlc_line_checker.sv
// Multi-channel HDLC line checker with a shared saturating error counter.
module hdlc_line_checker
  import hdlc_chk_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = 16,
  localparam int BYTE_W   = $clog2(MAX_BYTES + 2)
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [CHANNELS-1:0]        Line,
  input  logic [CHANNELS-1:0]        Enable,
  input  logic                       ErrClr,
  output logic [CHANNELS-1:0]        FlagDetect,
  output logic [CHANNELS-1:0]        AbortDetect,
  output logic [CHANNELS-1:0]        IdleDetect,
  output logic [CHANNELS-1:0]        FrameEnd,
  output logic [CHANNELS-1:0]        AlignErr,
  output logic [CHANNELS-1:0]        Overflow,
  output logic [CHANNELS*BYTE_W-1:0] FrameBytes,
  output logic [CNT_W-1:0]           ErrCnt
);

  localparam int EVT_W = $clog2(CHANNELS + 1);
  localparam int SUM_W = CNT_W + EVT_W;
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  chanEvt_t            evt [CHANNELS];
  logic [CHANNELS-1:0] errEvt;
  logic [EVT_W-1:0]    evtCnt;
  logic [SUM_W-1:0]    cntBase, cntSum;

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    hdlc_chk_chan #(.MAX_BYTES(MAX_BYTES)) uChan (
      .Clk        (Clk),
      .Rst        (Rst),
      .Line       (Line[g]),
      .Enable     (Enable[g]),
      .Evt        (evt[g]),
      .Idle       (IdleDetect[g]),
      .FrameBytes (FrameBytes[g*BYTE_W +: BYTE_W])
    );
    assign FlagDetect[g]  = evt[g].flag;
    assign AbortDetect[g] = evt[g].abort;
    assign FrameEnd[g]    = evt[g].frameEnd;
    assign AlignErr[g]    = evt[g].alignErr;
    assign Overflow[g]    = evt[g].overflow;
    assign errEvt[g]      = evt[g].frameEnd & (evt[g].alignErr | evt[g].overflow);
  end

  // Count channels reporting an error this cycle.
  always_comb begin
    evtCnt = '0;
    for (int i = 0; i < CHANNELS; i++) evtCnt = evtCnt + EVT_W'(errEvt[i]);
  end

  // Clear replaces the old total rather than dropping this cycle's events.
  assign cntBase = ErrClr ? '0 : SUM_W'(ErrCnt);
  assign cntSum  = cntBase + SUM_W'(evtCnt);

  // Saturating error counter.
  always_ff @(posedge Clk) begin
    if (!Rst)                         ErrCnt <= '0;
    else if (cntSum > SUM_W'(ERR_MAX)) ErrCnt <= ERR_MAX;
    else                              ErrCnt <= cntSum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_hdlc_line_checker.sv
// Directed bench for hdlc_line_checker: bit streams built with stuffing, events tallied per cycle.
module tb_hdlc_line_checker;

  localparam int BYTE_W = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Line, Enable;
  logic        ErrClr;
  logic [1:0]  FlagDetect, AbortDetect, IdleDetect, FrameEnd, AlignErr, Overflow;
  logic [15:0] FrameBytes;
  logic [15:0] ErrCnt;
  logic [1:0]  flag2, abort2, idle2, end2, align2, ovf2;
  logic [15:0] bytes2;
  logic [1:0]  errCnt2;

  hdlc_line_checker dut (
    .Clk(Clk), .Rst(Rst), .Line(Line), .Enable(Enable), .ErrClr(ErrClr),
    .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .IdleDetect(IdleDetect),
    .FrameEnd(FrameEnd), .AlignErr(AlignErr), .Overflow(Overflow),
    .FrameBytes(FrameBytes), .ErrCnt(ErrCnt)
  );

  hdlc_line_checker #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .Line(Line), .Enable(Enable), .ErrClr(ErrClr),
    .FlagDetect(flag2), .AbortDetect(abort2), .IdleDetect(idle2),
    .FrameEnd(end2), .AlignErr(align2), .Overflow(ovf2),
    .FrameBytes(bytes2), .ErrCnt(errCnt2)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0, nFail = 0;
  int nFlag[2], nAbort[2], nEnd[2], nEnd2[2], sRun[2];
  logic lastAlign[2], lastOvf[2], idleAtAbort[2];
  logic clrOnEnd = 1'b0;
  logic [15:0] errAtClr;
  bit q0[$], q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fb(input int c);
    return FrameBytes[c*BYTE_W +: BYTE_W];
  endfunction

  task automatic clearCounts();
    for (int c = 0; c < 2; c++) begin
      nFlag[c] = 0; nAbort[c] = 0; nEnd[c] = 0; nEnd2[c] = 0;
      lastAlign[c] = 1'b0; lastOvf[c] = 1'b0; idleAtAbort[c] = 1'bx;
    end
  endtask

  // Drive one bit per channel, then tally the registered responses.
  task automatic tick(input logic [1:0] b);
    Line = b;
    @(posedge Clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (FlagDetect[c]) nFlag[c]++;
      if (AbortDetect[c]) begin nAbort[c]++; idleAtAbort[c] = IdleDetect[c]; end
      if (FrameEnd[c]) begin nEnd[c]++; lastAlign[c] = AlignErr[c]; lastOvf[c] = Overflow[c]; end
      if (end2[c]) nEnd2[c]++;
    end
    if (clrOnEnd && FrameEnd != 2'b00) begin
      errAtClr = ErrCnt; ErrClr = 1'b1; clrOnEnd = 1'b0;
    end else ErrClr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(2'b11);
  endtask

  task automatic pushBit(input int ch, input bit b);
    if (ch == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic pushData(input int ch, input bit b);
    pushBit(ch, b);
    if (b) begin
      sRun[ch]++;
      if (sRun[ch] == 5) begin pushBit(ch, 1'b0); sRun[ch] = 0; end
    end else sRun[ch] = 0;
  endtask

  task automatic pushByte(input int ch, input logic [7:0] v);
    for (int i = 0; i < 8; i++) pushData(ch, v[i]);
  endtask

  task automatic pushFlag(input int ch);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) pushBit(ch, f[i]);
    sRun[ch] = 0;
  endtask

  task automatic push13(input int ch);
    logic [12:0] v;
    v = 13'b1011001101011;
    for (int i = 0; i < 13; i++) pushData(ch, v[i]);
  endtask

  task automatic runStreams();
    logic [1:0] b;
    while (q0.size() > 0 || q1.size() > 0) begin
      b = 2'b11;
      if (q0.size() > 0) b[0] = q0.pop_front();
      if (q1.size() > 0) b[1] = q1.pop_front();
      tick(b);
    end
  endtask

  initial begin
    Rst = 1'b0; Enable = 2'b11; Line = 2'b11; ErrClr = 1'b0;
    sRun[0] = 0; sRun[1] = 0;
    clearCounts();

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_flag",  32'(FlagDetect), 0);
    chk("rst_abort", 32'(AbortDetect), 0);
    chk("rst_idle",  32'(IdleDetect), 0);
    chk("rst_end",   32'(FrameEnd), 0);
    chk("rst_bytes", 32'(FrameBytes), 0);
    chk("rst_errcnt", 32'(ErrCnt), 0);
    Rst = 1'b1;
    idle(10);
    chk("idle_after_rst", 32'(IdleDetect), 2'b11);

    // Ch0: 16-byte frame with 0x7E and 0xFF inside
    clearCounts();
    pushFlag(0);
    for (int i = 0; i < 16; i++)
      pushByte(0, (i == 3) ? 8'h7E : (i == 7) ? 8'hFF : 8'(i * 29 + 3));
    pushFlag(0);
    runStreams(); idle(12);
    chk("a_flags", nFlag[0], 2);
    chk("a_end", nEnd[0], 1);
    chk("a_bytes", 32'(fb(0)), 16);
    chk("a_align", 32'(lastAlign[0]), 0);
    chk("a_ovf", 32'(lastOvf[0]), 0);
    chk("a_errcnt", 32'(ErrCnt), 0);
    chk("a_ch1_end", nEnd[1], 0);

    // Ch1: 13-bit frame
    clearCounts();
    pushFlag(1); push13(1); pushFlag(1);
    runStreams(); idle(12);
    chk("b_end", nEnd[1], 1);
    chk("b_align", 32'(lastAlign[1]), 1);
    chk("b_ovf", 32'(lastOvf[1]), 0);
    chk("b_bytes", 32'(fb(1)), 1);
    chk("b_errcnt", 32'(ErrCnt), 1);
    chk("b_errcnt2", 32'(errCnt2), 1);
    chk("b_ch0_held", 32'(fb(0)), 16);

    // Ch0: abort after 3 bytes, idle follows
    clearCounts();
    pushFlag(0); pushByte(0, 8'h12); pushByte(0, 8'h34); pushByte(0, 8'h56);
    pushBit(0, 1'b0);
    for (int i = 0; i < 8; i++) pushBit(0, 1'b1);
    runStreams();
    chk("c_idle_now", 32'(IdleDetect[0]), 1);
    idle(12);
    chk("c_abort", nAbort[0], 1);
    chk("c_idle_at_abort", 32'(idleAtAbort[0]), 0);
    chk("c_end", nEnd[0], 0);
    chk("c_errcnt", 32'(ErrCnt), 1);

    // Ch0: 130-byte frame overflows
    clearCounts();
    pushFlag(0);
    for (int i = 0; i < 130; i++) pushByte(0, 8'(i * 37 + 11));
    pushFlag(0);
    runStreams(); idle(12);
    chk("d_end", nEnd[0], 1);
    chk("d_bytes", 32'(fb(0)), 129);
    chk("d_ovf", 32'(lastOvf[0]), 1);
    chk("d_align", 32'(lastAlign[0]), 0);
    chk("d_errcnt", 32'(ErrCnt), 2);

    // Both channels misaligned together, then ch1 alone
    clearCounts();
    for (int c = 0; c < 2; c++) begin pushFlag(c); push13(c); pushFlag(c); end
    runStreams(); idle(12);
    chk("e1_end0", nEnd[0], 1);
    chk("e1_end1", nEnd[1], 1);
    chk("e1_errcnt", 32'(ErrCnt), 4);
    chk("e1_errcnt2_sat", 32'(errCnt2), 3);
    chk("e1_dut2_end", nEnd2[1], 1);
    clearCounts();
    pushFlag(1); push13(1); pushFlag(1);
    runStreams(); idle(12);
    chk("e2_errcnt", 32'(ErrCnt), 5);
    chk("e2_errcnt2_sat", 32'(errCnt2), 3);

    // Clear in the same cycle as two error events
    clearCounts();
    clrOnEnd = 1'b1;
    for (int c = 0; c < 2; c++) begin pushFlag(c); push13(c); pushFlag(c); end
    runStreams(); idle(12);
    chk("e3_before_clr", 32'(errAtClr), 5);
    chk("e3_errcnt", 32'(ErrCnt), 2);
    chk("e3_errcnt2", 32'(errCnt2), 2);

    // Enable low mid-frame on ch1, then a fresh frame
    clearCounts();
    pushFlag(1); pushByte(1, 8'hA5); pushByte(1, 8'h3C);
    runStreams();
    Enable = 2'b01;
    idle(3);
    chk("f_en_idle", 32'(IdleDetect[1]), 0);
    chk("f_en_held", 32'(fb(1)), 1);
    Enable = 2'b11;
    pushFlag(1);
    for (int i = 0; i < 5; i++) pushByte(1, 8'(i * 17 + 5));
    pushFlag(1);
    runStreams(); idle(12);
    chk("f_en_end", nEnd[1], 1);
    chk("f_en_bytes", 32'(fb(1)), 5);
    chk("f_en_errcnt", 32'(ErrCnt), 2);

    // Reset mid-frame on ch0, then a fresh frame
    clearCounts();
    pushFlag(0); pushByte(0, 8'hC3); pushByte(0, 8'h96);
    runStreams();
    Rst = 1'b0;
    idle(2);
    chk("g_rst_bytes", 32'(FrameBytes), 0);
    chk("g_rst_errcnt", 32'(ErrCnt), 0);
    Rst = 1'b1;
    pushFlag(0);
    for (int i = 0; i < 4; i++) pushByte(0, 8'(i * 41 + 9));
    pushFlag(0);
    runStreams(); idle(12);
    chk("g_end", nEnd[0], 1);
    chk("g_bytes", 32'(fb(0)), 4);
    chk("g_errcnt", 32'(ErrCnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/hdlc_line_checker.md
HDLC_LINE_CHECKER -- requirements
Module: hdlc_line_checker

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent serial lines checked.
REQ-002 SHALL have parameter MAX_BYTES, default 128, maximum legal destuffed bytes per frame (FCS included); legal range 2..254.
REQ-003 SHALL have parameter CNT_W, default 16, width of the error counter.
REQ-004 SHALL have derived constant BYTE_W = clog2(MAX_BYTES+2).
REQ-005 Clk  in  1  single clock; all state is updated on its rising edge.
REQ-006 Rst  in  1  reset; synchronous, active-low.
REQ-007 Line  in  CHANNELS  serial bit per channel, one bit sampled per Clk.
REQ-008 Enable  in  CHANNELS  per-channel checking enable.
REQ-009 ErrClr  in  1  synchronous clear of ErrCnt.
REQ-010 FlagDetect  out  CHANNELS  one-cycle pulse per completed flag.
REQ-011 AbortDetect  out  CHANNELS  one-cycle pulse per abort inside a frame.
REQ-012 IdleDetect  out  CHANNELS  level signal; channel in HUNT with a ones-run of 8 or more.
REQ-013 FrameEnd  out  CHANNELS  one-cycle pulse on a closing flag that ends a non-empty frame.
REQ-014 AlignErr  out  CHANNELS  qualified by FrameEnd; destuffed bit count is not a multiple of 8.
REQ-015 Overflow  out  CHANNELS  qualified by FrameEnd; byte count exceeds MAX_BYTES.
REQ-016 FrameBytes  out  CHANNELS*BYTE_W  per-channel byte count of the last ended frame; held until the next FrameEnd.
REQ-017 ErrCnt  out  CNT_W  saturating count of error events.

Function
REQ-018 Each channel SHALL keep an 8-bit history window and a ones-run counter that saturates at 8.
REQ-019 Flag: window equals 0111_1110 on the current bit; the response SHALL be registered, so the pulse appears on the cycle after that bit is sampled.
REQ-020 Per-channel FSM states SHALL be HUNT, OPEN and DATA.
REQ-021 HUNT SHALL move to OPEN on a flag.
REQ-022 OPEN SHALL stay in OPEN on a flag (back-to-back or shared flags) and SHALL move to DATA on the first destuffed data bit.
REQ-023 DATA SHALL move to OPEN on a flag, asserting FrameEnd.
REQ-024 In OPEN or DATA, 7 consecutive ones SHALL pulse AbortDetect, move the channel to HUNT and suppress FrameEnd for that frame.
REQ-025 Zero removal: in OPEN or DATA, a 0 that immediately follows exactly five 1s SHALL be discarded and not counted.
REQ-026 Frame bit count SHALL equal the destuffed bits between the end of the opening flag and the start of the closing flag.
REQ-027 At FrameEnd, FrameBytes SHALL equal bit count / 8, saturating at MAX_BYTES+1.
REQ-028 At FrameEnd, AlignErr SHALL be asserted when bit count mod 8 is not 0.
REQ-029 At FrameEnd, Overflow SHALL be asserted when the byte count exceeds MAX_BYTES.
REQ-030 The bit counter SHALL saturate and SHALL NOT wrap.
REQ-031 An error event SHALL be a FrameEnd with AlignErr or Overflow set; abort SHALL NOT be an error event.
REQ-032 Each cycle, ErrCnt SHALL add the number of channels with an error event (popcount) and saturate at all-ones.
REQ-033 ErrClr with simultaneous events SHALL load ErrCnt with that cycle's popcount, so no new events are lost.
REQ-034 Enable low SHALL force the channel to HUNT, clear its window, run and bit counters, and suppress all its pulses and IdleDetect; FrameBytes SHALL be held.
REQ-035 Enable rising SHALL start the channel in HUNT with an empty window, so a flag is detectable 8 bits later at the earliest.
REQ-036 Channels SHALL be fully independent; simultaneous events on all channels SHALL be legal.

Reset
REQ-037 While Rst is sampled low, all FSMs SHALL be in HUNT, windows and counters 0, and every output 0 (including FrameBytes and ErrCnt).
REQ-038 Reset asserted mid-frame SHALL discard the frame with no FrameEnd and no error count.
REQ-039 The first bit sampled after reset release SHALL be the first bit of a new window.

Structure
REQ-040 Package hdlc_chk_pkg SHALL hold the FSM state enum, the flag/abort pattern constants and the per-channel event struct.
REQ-041 Sub-module hdlc_chk_chan SHALL implement one channel (window, destuffing, FSM, counters).
REQ-042 The top level SHALL instantiate CHANNELS hdlc_chk_chan copies and hold the popcount/saturating ErrCnt logic.

Verification
REQ-043 Ch0: idle ones, flag, 16 data bytes containing 0x7E (stuffed), flag -> FlagDetect x2, FrameEnd, FrameBytes=16, AlignErr=0, Overflow=0, ErrCnt=0.
REQ-044 Ch1: flag, 13 data bits, flag -> FrameEnd, AlignErr=1, ErrCnt=1.
REQ-045 Ch0: flag, 3 bytes, then 0 followed by 7 ones -> AbortDetect, no FrameEnd, IdleDetect high 8 bits later, ErrCnt unchanged.
REQ-046 MAX_BYTES=128; frame of 130 bytes -> FrameEnd, FrameBytes=129, Overflow=1.
REQ-047 Both channels raise AlignErr in the same cycle as ErrClr while ErrCnt=5 -> ErrCnt=2; with CNT_W=2 and ErrCnt=3, one further error -> ErrCnt=3.
REQ-048 Rst low, or Enable low, mid-frame, then a fresh frame -> no stale FrameEnd; the new frame reports correct FrameBytes.
